multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 65 ++++++
 rtl/multicycle_controller_alu_decoder.sv | 56 +++++
 rtl/multicycle_controller.sv | 160 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: opcodes, functs,
// ALU operation codes, FSM state codes and datapath mux selects.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NOR  = 3'd5,
    ALU_SLT  = 3'd6,
    ALU_SLTU = 3'd7
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_IMMEX  = 4'd8,
    S_IMMWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode: R-type funct and immediate opcode mapping, plus the
// sign/zero extension choice for immediates.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output alu_op_t    r_alu_op,
  output logic       r_valid,
  output alu_op_t    i_alu_op,
  output logic       i_valid,
  output logic       sgn_zero
);

  always_comb begin
    r_alu_op = ALU_ADD;
    r_valid  = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: r_alu_op = ALU_ADD;
      FN_SUB, FN_SUBU: r_alu_op = ALU_SUB;
      FN_AND:          r_alu_op = ALU_AND;
      FN_OR:           r_alu_op = ALU_OR;
      FN_XOR:          r_alu_op = ALU_XOR;
      FN_NOR:          r_alu_op = ALU_NOR;
      FN_SLT:          r_alu_op = ALU_SLT;
      FN_SLTU:         r_alu_op = ALU_SLTU;
      default:         r_valid  = 1'b0;
    endcase
  end

  // Logical immediates are zero-extended; everything else sign-extends.
  always_comb begin
    i_alu_op = ALU_ADD;
    i_valid  = 1'b1;
    sgn_zero = 1'b1;
    case (op)
      OP_ADDI, OP_ADDIU: i_alu_op = ALU_ADD;
      OP_SLTI:           i_alu_op = ALU_SLT;
      OP_SLTIU:          i_alu_op = ALU_SLTU;
      OP_ANDI: begin
        i_alu_op = ALU_AND;
        sgn_zero = 1'b0;
      end
      OP_ORI: begin
        i_alu_op = ALU_OR;
        sgn_zero = 1'b0;
      end
      OP_XORI: begin
        i_alu_op = ALU_XOR;
        sgn_zero = 1'b0;
      end
      default: i_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller FSM: registered state, combinational control decode
// of state, instruction fields, ALU zero flag and memory handshake.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned HAS_JUMP = 1,
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegW,
  output logic               ALUSrcA,
  output logic               SgnZero,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic [3:0]         state_o,
  output logic               illegal
);

  if (ALUOP_W < 3) begin : g_aluop_w_check
    $error("multicycle_controller: ALUOP_W must be at least 3");
  end

  state_t  state_q, state_d;
  alu_op_t r_alu_op, i_alu_op, alu_op;
  logic    r_valid, i_valid, imm_sgn_zero;
  logic    mem_rdy, is_jump;
  logic    irwrite_c, pcwrite_c, memwrite_c, regw_c, illegal_c;

  alu_decoder u_alu_decoder (
    .op       (op),
    .funct    (funct),
    .r_alu_op (r_alu_op),
    .r_valid  (r_valid),
    .i_alu_op (i_alu_op),
    .i_valid  (i_valid),
    .sgn_zero (imm_sgn_zero)
  );

  assign mem_rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign is_jump = (HAS_JUMP != 0) && (op == OP_J);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    pcwrite_c  = 1'b0;
    MemToReg   = 1'b0;
    RegDst     = 1'b0;
    regw_c     = 1'b0;
    ALUSrcA    = 1'b0;
    SgnZero    = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSrc      = PCSRC_ALU;
    alu_op     = ALU_ADD;
    illegal_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        irwrite_c = mem_rdy;
        pcwrite_c = mem_rdy;
        state_d   = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        if (op == OP_LW || op == OP_SW)       state_d = S_MEMADR;
        else if (op == OP_RTYPE && r_valid)   state_d = S_EXEC;
        else if (op != OP_RTYPE && i_valid)   state_d = S_IMMEX;
        else if (op == OP_BEQ || op == OP_BNE) state_d = S_BRANCH;
        else if (is_jump)                     state_d = S_JUMP;
        else                                  illegal_c = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        SgnZero = 1'b1;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemToReg = 1'b1;
        regw_c   = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        memwrite_c = 1'b1;
        state_d    = mem_rdy ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        alu_op  = r_alu_op;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst = 1'b1;
        regw_c = 1'b1;
        alu_op = r_alu_op;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_op  = i_alu_op;
        SgnZero = imm_sgn_zero;
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regw_c  = 1'b1;
        alu_op  = i_alu_op;
        SgnZero = imm_sgn_zero;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        alu_op    = ALU_SUB;
        PCSrc     = PCSRC_ALUOUT;
        pcwrite_c = (op == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        PCSrc     = PCSRC_JUMP;
        pcwrite_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are forced low while reset is held, even though the state
  // register already shows FETCH (whose IRWrite/PCWrite follow mem_ready).
  assign IRWrite  = irwrite_c  & rst_n;
  assign PCWrite  = pcwrite_c  & rst_n;
  assign MemWrite = memwrite_c & rst_n;
  assign RegW     = regw_c     & rst_n;
  assign illegal  = illegal_c  & rst_n;
  assign ALUOP    = ALUOP_W'(alu_op);
  assign state_o  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-level reference
// model driven with directed and randomized instruction streams.
module tb_multicycle_controller;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                 P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_IMMEX = 8, P_IMMWB = 9,
                 P_BRANCH = 10, P_JUMP = 11;
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_IMM = 3, C_BR = 4, C_J = 5, C_ILL = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst2_n;
  logic [5:0] op, funct, op2, funct2;
  logic       zero, mem_ready, zero2, mem_ready2;

  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, MemToReg, RegDst, RegW, ALUSrcA, SgnZero;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUOP;
  logic [3:0] state_o;
  logic       illegal;

  logic       IorD2, MemRead2, MemWrite2, IRWrite2, PCWrite2, MemToReg2, RegDst2, RegW2, ALUSrcA2, SgnZero2;
  logic [1:0] ALUSrcB2, PCSrc2;
  logic [3:0] ALUOP2;
  logic [3:0] state2;
  logic       illegal2;

  multicycle_controller #(.ALUOP_W(3), .HAS_JUMP(1), .MEM_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegW(RegW), .ALUSrcA(ALUSrcA), .SgnZero(SgnZero),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOP(ALUOP), .state_o(state_o), .illegal(illegal)
  );

  multicycle_controller #(.ALUOP_W(4), .HAS_JUMP(0), .MEM_WAIT(0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .op(op2), .funct(funct2), .zero(zero2), .mem_ready(mem_ready2),
    .IorD(IorD2), .MemRead(MemRead2), .MemWrite(MemWrite2), .IRWrite(IRWrite2), .PCWrite(PCWrite2),
    .MemToReg(MemToReg2), .RegDst(RegDst2), .RegW(RegW2), .ALUSrcA(ALUSrcA2), .SgnZero(SgnZero2),
    .ALUSrcB(ALUSrcB2), .PCSrc(PCSrc2), .ALUOP(ALUOP2), .state_o(state2), .illegal(illegal2)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // ---------------- reference model ----------------
  function automatic int funct_alu(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 0;
      6'h22, 6'h23: return 1;
      6'h24:        return 2;
      6'h25:        return 3;
      6'h26:        return 4;
      6'h27:        return 5;
      6'h2a:        return 6;
      6'h2b:        return 7;
      default:      return -1;
    endcase
  endfunction

  function automatic int op_alu(input logic [5:0] o);
    case (o)
      6'h08, 6'h09: return 0;
      6'h0a:        return 6;
      6'h0b:        return 7;
      6'h0c:        return 2;
      6'h0d:        return 3;
      6'h0e:        return 4;
      default:      return -1;
    endcase
  endfunction

  function automatic int classify(input logic [5:0] o, input logic [5:0] f, input int hj);
    if (o == 6'h23) return C_LW;
    if (o == 6'h2b) return C_SW;
    if (o == 6'h00) return (funct_alu(f) >= 0) ? C_R : C_ILL;
    if (op_alu(o) >= 0) return C_IMM;
    if (o == 6'h04 || o == 6'h05) return C_BR;
    if (o == 6'h02 && hj != 0) return C_J;
    return C_ILL;
  endfunction

  // Expected control vector for one cycle spent in phase p.
  function automatic logic [21:0] exp_vec(input int p, input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input logic mr, input int hj);
    logic iord, mrd, mwr, irw, pcw, m2r, rdst, regw, srca, sgn, ill;
    logic [1:0] srcb, pcs;
    int alu;
    {iord, mrd, mwr, irw, pcw, m2r, rdst, regw, srca, sgn, ill} = '0;
    srcb = 2'b00;
    pcs  = 2'b00;
    alu  = 0;
    case (p)
      P_FETCH:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
      P_DECODE: begin srcb = 2'b11; ill = (classify(o, f, hj) == C_ILL); end
      P_MEMADR: begin srca = 1'b1; srcb = 2'b10; sgn = 1'b1; end
      P_MEMRD:  begin iord = 1'b1; mrd = 1'b1; end
      P_MEMWB:  begin m2r = 1'b1; regw = 1'b1; end
      P_MEMWR:  begin iord = 1'b1; mwr = 1'b1; end
      P_EXEC:   begin srca = 1'b1; alu = funct_alu(f); end
      P_ALUWB:  begin rdst = 1'b1; regw = 1'b1; alu = funct_alu(f); end
      P_IMMEX:  begin srca = 1'b1; srcb = 2'b10; alu = op_alu(o); sgn = !(o inside {6'h0c, 6'h0d, 6'h0e}); end
      P_IMMWB:  begin regw = 1'b1; alu = op_alu(o); sgn = !(o inside {6'h0c, 6'h0d, 6'h0e}); end
      P_BRANCH: begin srca = 1'b1; alu = 1; pcs = 2'b01; pcw = (o == 6'h05) ? !z : z; end
      P_JUMP:   begin pcs = 2'b10; pcw = 1'b1; end
      default:  ;
    endcase
    return {4'(p), iord, mrd, mwr, irw, pcw, m2r, rdst, regw, srca, sgn, srcb, pcs, 3'(alu), ill};
  endfunction

  function automatic logic [21:0] obs_vec();
    return {state_o, IorD, MemRead, MemWrite, IRWrite, PCWrite, MemToReg, RegDst, RegW,
            ALUSrcA, SgnZero, ALUSrcB, PCSrc, ALUOP, illegal};
  endfunction

  function automatic logic [21:0] obs2_vec();
    return {state2, IorD2, MemRead2, MemWrite2, IRWrite2, PCWrite2, MemToReg2, RegDst2, RegW2,
            ALUSrcA2, SgnZero2, ALUSrcB2, PCSrc2, ALUOP2[2:0], illegal2};
  endfunction

  // Runs one instruction on dut: fw fetch wait cycles, mw memory wait cycles.
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input logic iz,
                           input int fw, input int mw, output int nwr);
    int ph[$];
    int waits;
    bit memph;
    ph.push_back(P_FETCH);
    ph.push_back(P_DECODE);
    case (classify(iop, ifn, 1))
      C_LW:  begin ph.push_back(P_MEMADR); ph.push_back(P_MEMRD); ph.push_back(P_MEMWB); end
      C_SW:  begin ph.push_back(P_MEMADR); ph.push_back(P_MEMWR); end
      C_R:   begin ph.push_back(P_EXEC);   ph.push_back(P_ALUWB); end
      C_IMM: begin ph.push_back(P_IMMEX);  ph.push_back(P_IMMWB); end
      C_BR:  ph.push_back(P_BRANCH);
      C_J:   ph.push_back(P_JUMP);
      default: ;
    endcase
    nwr = 0;
    foreach (ph[i]) begin
      memph = (ph[i] == P_FETCH || ph[i] == P_MEMRD || ph[i] == P_MEMWR);
      waits = (ph[i] == P_FETCH) ? fw : (memph ? mw : 0);
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        op = iop; funct = ifn; zero = iz;
        mem_ready = memph ? (w == waits) : 1'($urandom_range(0, 1));
        #1;
        chk($sformatf("cycle_phase%0d_op%02h", ph[i], iop), 32'(obs_vec()),
            32'(exp_vec(ph[i], iop, ifn, iz, mem_ready, 1)));
        if (MemWrite) nwr++;
      end
    end
  endtask

  logic [5:0] legal_f [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
  logic [5:0] imm_ops [7]  = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e};

  initial begin
    int nwr, n, cls;
    bit found;
    logic [5:0] ro, rf;
    rst_n = 1'b0; rst2_n = 1'b0;
    op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    op2 = '0; funct2 = '0; zero2 = 1'b0; mem_ready2 = 1'b0;

    // Reset: FETCH decode with write enables suppressed although mem_ready=1.
    @(negedge clk); #1;
    chk("reset_vector", 32'(obs_vec()), 32'(exp_vec(P_FETCH, op, funct, zero, 1'b0, 1)));
    chk("reset_irwrite", 32'(IRWrite), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_instr(6'h23, 6'h00, 1'b0, 0, 0, nwr);           // lw
    run_instr(6'h2b, 6'h15, 1'b0, 0, 3, nwr);           // sw, 3 wait cycles
    chk("sw_memwrite_cycles", 32'(nwr), 32'd4);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, nwr);           // beq taken
    run_instr(6'h05, 6'h00, 1'b1, 0, 0, nwr);           // bne not taken
    run_instr(6'h00, 6'h27, 1'b0, 1, 0, nwr);           // nor
    run_instr(6'h0d, 6'h3f, 1'b0, 0, 0, nwr);           // ori
    run_instr(6'h3f, 6'h00, 1'b0, 0, 0, nwr);           // illegal op
    run_instr(6'h00, 6'h08, 1'b0, 0, 0, nwr);           // illegal funct (jr)
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, nwr);           // j
    run_instr(6'h23, 6'h00, 1'b0, 2, 2, nwr);           // lw with waits
    @(negedge clk); #1;
    chk("after_lw_fetch", 32'(state_o), 32'd0);

    // Asynchronous reset during a MEMRD wait.
    op = 6'h23; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("memrd_wait_state", 32'(state_o), 32'd3);
    #2 rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("async_reset_state", 32'(state_o), 32'd0);
    chk("async_reset_regw", 32'(RegW), 32'd0);
    chk("async_reset_irwrite", 32'(IRWrite), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_instr(6'h0c, 6'h00, 1'b0, 0, 0, nwr);           // andi, first after reset

    // Randomized instruction stream.
    for (int k = 0; k < 40; k++) begin
      cls = int'($urandom_range(0, 7));
      rf = 6'($urandom);
      case (cls)
        0: ro = 6'h23;
        1: ro = 6'h2b;
        2: begin ro = 6'h00; rf = legal_f[$urandom_range(0, 9)]; end
        3: ro = imm_ops[$urandom_range(0, 6)];
        4: ro = ($urandom_range(0, 1) != 0) ? 6'h05 : 6'h04;
        5: ro = 6'h02;
        6: begin
          ro = 6'h3f;
          for (int t = 0; t < 50; t++) begin
            rf = 6'($urandom);
            if (classify(rf, 6'h00, 1) == C_ILL && rf != 6'h00) begin ro = rf; break; end
          end
          rf = 6'($urandom);
        end
        default: begin
          ro = 6'h00; rf = 6'h3f;
          for (int t = 0; t < 50; t++) begin
            rf = 6'($urandom);
            if (funct_alu(rf) < 0) break;
          end
          if (funct_alu(rf) >= 0) rf = 6'h3f;
        end
      endcase
      run_instr(ro, rf, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), nwr);
    end

    // Second instance: no jump decode, mem_ready ignored (held low).
    @(posedge clk); #1 rst2_n = 1'b1;
    op2 = 6'h02; funct2 = '0; zero2 = 1'b0; mem_ready2 = 1'b0;
    @(negedge clk); #1;
    chk("nj_fetch", 32'(obs2_vec()), 32'(exp_vec(P_FETCH, op2, funct2, zero2, 1'b1, 0)));
    @(negedge clk); #1;
    chk("nj_decode_illegal", 32'(obs2_vec()), 32'(exp_vec(P_DECODE, op2, funct2, zero2, 1'b1, 0)));
    @(negedge clk); #1;
    chk("nj_back_fetch", 32'(obs2_vec()), 32'(exp_vec(P_FETCH, op2, funct2, zero2, 1'b1, 0)));
    chk("nj_aluop_msb", 32'(ALUOP2[3]), 32'd0);
    op2 = 6'h23;
    n = 1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (state2 == 4'd0) begin found = 1'b1; break; end
      n++;
    end
    chk("nw_lw_latency", 32'(found ? n : 99), 32'd5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
